// File: rtl/mem_except_ctrl_pkg.sv
// Shared CP0 definitions for the MEM-stage exception path: register addresses,
// excepttype codes, exception flag bit positions and the flush FSM states.
package mem_except_ctrl_pkg;

    localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
    localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
    localparam logic [4:0] CP0_REG_STATUS  = 5'd12;
    localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_REG_EPC     = 5'd14;
    localparam logic [4:0] CP0_REG_PRID    = 5'd15;
    localparam logic [4:0] CP0_REG_CONFIG  = 5'd16;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam int FLAG_SYSCALL = 8;
    localparam int FLAG_INVALID = 9;
    localparam int FLAG_TRAP    = 10;
    localparam int FLAG_OV      = 11;
    localparam int FLAG_ERET    = 12;

    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic        RstEnable = 1'b1;

    typedef enum logic {ST_IDLE, ST_HOLD} flush_state_e;

    // Only the software-writable cause bits (IP1:IP0, IV, WP) take the pending write.
    function automatic logic [31:0] cause_merge(input logic [31:0] cause, input logic [31:0] wdata);
        logic [31:0] merged;
        merged        = cause;
        merged[9:8]   = wdata[9:8];
        merged[22]    = wdata[22];
        merged[23]    = wdata[23];
        return merged;
    endfunction

endpackage

// File: rtl/mem_except_ctrl_exc_priority_enc.sv
// Fixed-priority encoder turning the MEM instruction's exception flags plus the
// pending-interrupt bit into a single excepttype code.
module exc_priority_enc
    import mem_except_ctrl_pkg::*;
(
    input  logic [4:0]  flags_i,   // bit 0 = syscall ... bit 4 = eret
    input  logic        int_p_i,
    output logic [31:0] code_o
);

    always_comb begin
        code_o = ZeroWord;
        if (int_p_i)                                  code_o = EXC_INT;
        else if (flags_i[FLAG_SYSCALL - FLAG_SYSCALL]) code_o = EXC_SYSCALL;
        else if (flags_i[FLAG_INVALID - FLAG_SYSCALL]) code_o = EXC_INVALID;
        else if (flags_i[FLAG_TRAP    - FLAG_SYSCALL]) code_o = EXC_TRAP;
        else if (flags_i[FLAG_OV      - FLAG_SYSCALL]) code_o = EXC_OV;
        else if (flags_i[FLAG_ERET    - FLAG_SYSCALL]) code_o = EXC_ERET;
    end

endmodule

// File: rtl/mem_except_ctrl.sv
// MEM-stage exception resolver: owns the MEM/WB CP0 write register, forwards it
// over CP0 state, resolves the excepttype and drives the pipeline flush/redirect.
module mem_except_ctrl
    import mem_except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int          FLUSH_CYCLES = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_exc_flags_i,
    input  logic [31:0] mem_inst_addr_i,
    input  logic        mem_in_delayslot_i,
    input  logic        mem_cp0_we_i,
    input  logic [4:0]  mem_cp0_waddr_i,
    input  logic [31:0] mem_cp0_wdata_i,
    input  logic        mem_stall_i,
    input  logic        wb_stall_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_wdata_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_inst_addr_o,
    output logic        exc_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [2:0] HOLD_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         USE_HOLD  = (FLUSH_CYCLES > 1);

    logic         cp0_we_q, cp0_we_d;
    logic [4:0]   cp0_waddr_q, cp0_waddr_d;
    logic [31:0]  cp0_wdata_q, cp0_wdata_d;
    flush_state_e state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [31:0]  new_pc_q, new_pc_d;

    logic [31:0]  status_eff, cause_eff, epc_eff, enc_code, redirect_pc;
    logic         int_p, exc_hit;

    // The WB write lands in CP0 only at the next edge, so overlay it here.
    always_comb begin
        status_eff = cp0_status_i;
        cause_eff  = cp0_cause_i;
        epc_eff    = cp0_epc_i;
        if (cp0_we_q) begin
            case (cp0_waddr_q)
                CP0_REG_STATUS: status_eff = cp0_wdata_q;
                CP0_REG_CAUSE:  cause_eff  = cause_merge(cp0_cause_i, cp0_wdata_q);
                CP0_REG_EPC:    epc_eff    = cp0_wdata_q;
                default: ;
            endcase
        end
        int_p = (|(cause_eff[15:8] & status_eff[15:8])) && !status_eff[1] && status_eff[0];
    end

    exc_priority_enc u_enc (
        .flags_i (mem_exc_flags_i[FLAG_ERET:FLAG_SYSCALL]),
        .int_p_i (int_p),
        .code_o  (enc_code)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            new_pc_q    <= ZeroWord;
            cp0_we_q    <= 1'b0;
            cp0_waddr_q <= 5'd0;
            cp0_wdata_q <= ZeroWord;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            new_pc_q    <= new_pc_d;
            cp0_we_q    <= cp0_we_d;
            cp0_waddr_q <= cp0_waddr_d;
            cp0_wdata_q <= cp0_wdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        new_pc_d = new_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_hit && USE_HOLD) begin
                    state_d  = ST_HOLD;
                    cnt_d    = HOLD_LOAD;
                    new_pc_d = redirect_pc;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        excepttype_o = ZeroWord;
        flush_o      = 1'b0;
        new_pc_o     = ZeroWord;
        exc_hit      = 1'b0;
        redirect_pc  = (enc_code == EXC_ERET) ? epc_eff : EXC_VECTOR;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid_i) excepttype_o = enc_code;
                exc_hit = (excepttype_o != ZeroWord);
                if (exc_hit) begin
                    flush_o  = 1'b1;
                    new_pc_o = redirect_pc;
                end
            end
            ST_HOLD: begin
                flush_o  = 1'b1;
                new_pc_o = new_pc_q;
            end
            default: ;
        endcase
    end

    // Flush (which covers the faulting instruction itself) outranks both stalls.
    always_comb begin
        cp0_we_d    = cp0_we_q;
        cp0_waddr_d = cp0_waddr_q;
        cp0_wdata_d = cp0_wdata_q;
        if (flush_o || (mem_stall_i && !wb_stall_i)) begin
            cp0_we_d    = 1'b0;
            cp0_waddr_d = 5'd0;
            cp0_wdata_d = ZeroWord;
        end else if (!wb_stall_i) begin
            cp0_we_d    = mem_valid_i && mem_cp0_we_i;
            cp0_waddr_d = mem_valid_i ? mem_cp0_waddr_i : 5'd0;
            cp0_wdata_d = mem_valid_i ? mem_cp0_wdata_i : ZeroWord;
        end
    end

    assign cp0_we_o           = cp0_we_q;
    assign cp0_waddr_o        = cp0_waddr_q;
    assign cp0_wdata_o        = cp0_wdata_q;
    assign exc_inst_addr_o    = mem_inst_addr_i;
    assign exc_in_delayslot_o = mem_in_delayslot_i;

endmodule

// File: tb/tb_mem_except_ctrl.sv
// Bench for mem_except_ctrl: two instances (1- and 3-cycle flush) share stimulus
// and are compared every cycle against a behavioural model, plus directed cases.
module tb_mem_except_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_dslot, mem_cp0_we, mem_stall, wb_stall;
    logic [31:0] mem_flags, mem_addr, mem_cp0_wdata, st_i, ca_i, epc_i;
    logic [4:0]  mem_cp0_waddr;

    logic        o_we    [2];
    logic [4:0]  o_waddr [2];
    logic [31:0] o_wdata [2];
    logic [31:0] o_exc   [2];
    logic [31:0] o_iaddr [2];
    logic        o_dslot [2];
    logic        o_flush [2];
    logic [31:0] o_npc   [2];

    always #5 clk = ~clk;

    mem_except_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_exc_flags_i(mem_flags),
        .mem_inst_addr_i(mem_addr), .mem_in_delayslot_i(mem_dslot), .mem_cp0_we_i(mem_cp0_we),
        .mem_cp0_waddr_i(mem_cp0_waddr), .mem_cp0_wdata_i(mem_cp0_wdata), .mem_stall_i(mem_stall),
        .wb_stall_i(wb_stall), .cp0_status_i(st_i), .cp0_cause_i(ca_i), .cp0_epc_i(epc_i),
        .cp0_we_o(o_we[0]), .cp0_waddr_o(o_waddr[0]), .cp0_wdata_o(o_wdata[0]),
        .excepttype_o(o_exc[0]), .exc_inst_addr_o(o_iaddr[0]), .exc_in_delayslot_o(o_dslot[0]),
        .flush_o(o_flush[0]), .new_pc_o(o_npc[0]));

    mem_except_ctrl #(.EXC_VECTOR(32'h20), .FLUSH_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .mem_valid_i(mem_valid), .mem_exc_flags_i(mem_flags),
        .mem_inst_addr_i(mem_addr), .mem_in_delayslot_i(mem_dslot), .mem_cp0_we_i(mem_cp0_we),
        .mem_cp0_waddr_i(mem_cp0_waddr), .mem_cp0_wdata_i(mem_cp0_wdata), .mem_stall_i(mem_stall),
        .wb_stall_i(wb_stall), .cp0_status_i(st_i), .cp0_cause_i(ca_i), .cp0_epc_i(epc_i),
        .cp0_we_o(o_we[1]), .cp0_waddr_o(o_waddr[1]), .cp0_wdata_o(o_wdata[1]),
        .excepttype_o(o_exc[1]), .exc_inst_addr_o(o_iaddr[1]), .exc_in_delayslot_o(o_dslot[1]),
        .flush_o(o_flush[1]), .new_pc_o(o_npc[1]));

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] @%0t: got %h want %h", nm, d, $time, act, exp);
        end
    endtask

    // Model: pending WB write as a record, flush hold as a count of remaining cycles.
    int          fc    [2] = '{1, 3};
    int          busy  [2] = '{0, 0};
    logic [31:0] lpc   [2] = '{32'h0, 32'h0};
    logic        m_we  [2] = '{1'b0, 1'b0};
    logic [4:0]  m_adr [2] = '{5'd0, 5'd0};
    logic [31:0] m_dat [2] = '{32'h0, 32'h0};

    always @(negedge clk) begin : compare
        logic [31:0] se, ce, ee, code, npc;
        logic        intp, fl;
        for (int d = 0; d < 2; d++) begin
            se = st_i; ce = ca_i; ee = epc_i;
            if (m_we[d] && m_adr[d] == 5'd12) se = m_dat[d];
            if (m_we[d] && m_adr[d] == 5'd14) ee = m_dat[d];
            if (m_we[d] && m_adr[d] == 5'd13)
                ce = (ca_i & ~32'h00C0_0300) | (m_dat[d] & 32'h00C0_0300);
            intp = ((ce[15:8] & se[15:8]) != 8'd0) && (se[1] == 1'b0) && (se[0] == 1'b1);
            code = 32'h0;
            if (mem_valid && busy[d] == 0) begin
                if (intp)              code = 32'h01;
                else if (mem_flags[8])  code = 32'h08;
                else if (mem_flags[9])  code = 32'h0a;
                else if (mem_flags[10]) code = 32'h0d;
                else if (mem_flags[11]) code = 32'h0c;
                else if (mem_flags[12]) code = 32'h0e;
            end
            fl  = (code != 0) || (busy[d] > 0);
            npc = (busy[d] > 0) ? lpc[d] : (code == 32'h0e) ? ee : 32'h20;
            if (started) begin
                chk("m_exc",   d, o_exc[d],   code);
                chk("m_flush", d, 32'(o_flush[d]), 32'(fl));
                if (fl) chk("m_npc", d, o_npc[d], npc);
                chk("m_we",    d, 32'(o_we[d]), 32'(m_we[d]));
                if (m_we[d]) begin
                    chk("m_waddr", d, 32'(o_waddr[d]), 32'(m_adr[d]));
                    chk("m_wdata", d, o_wdata[d], m_dat[d]);
                end
                chk("m_iaddr", d, o_iaddr[d], mem_addr);
                chk("m_dslot", d, 32'(o_dslot[d]), 32'(mem_dslot));
            end
            if (rst) begin
                busy[d] = 0; lpc[d] = 0; m_we[d] = 0; m_adr[d] = 0; m_dat[d] = 0;
            end else begin
                if (busy[d] > 0) busy[d]--;
                else if (code != 0) begin busy[d] = fc[d] - 1; lpc[d] = npc; end
                if (fl || (mem_stall && !wb_stall)) m_we[d] = 1'b0;
                else if (!wb_stall) begin
                    m_we[d]  = mem_valid && mem_cp0_we;
                    m_adr[d] = mem_cp0_waddr;
                    m_dat[d] = mem_cp0_wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        mem_valid = 0; mem_flags = 0; mem_addr = 0; mem_dslot = 0; mem_cp0_we = 0;
        mem_cp0_waddr = 0; mem_cp0_wdata = 0; mem_stall = 0; wb_stall = 0;
        st_i = 0; ca_i = 0; epc_i = 0;
    endtask

    initial begin
        rst = 1; idle();
        repeat (3) @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_we", d, 32'(o_we[d]), 0);
            chk("rst_flush", d, 32'(o_flush[d]), 0);
            chk("rst_npc", d, o_npc[d], 0);
        end
        tick(); rst = 0;

        // interrupt: IE set, IP2 pending and enabled
        st_i = 32'h401; ca_i = 32'h400; mem_valid = 1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("int_exc", d, o_exc[d], 32'h01);
            chk("int_flush", d, 32'(o_flush[d]), 1);
            chk("int_npc", d, o_npc[d], 32'h20);
        end
        tick(); idle(); tick(); tick(); tick();

        // pending STATUS write with EXL set masks the interrupt
        st_i = 32'h400; ca_i = 32'h400; mem_valid = 1;
        mem_cp0_we = 1; mem_cp0_waddr = 5'd12; mem_cp0_wdata = 32'h402;
        tick();
        st_i = 32'h401; mem_cp0_we = 0;
        @(negedge clk);
        chk("fwd_exc", 0, o_exc[0], 0);
        chk("fwd_we", 0, 32'(o_we[0]), 1);
        chk("fwd_waddr", 0, 32'(o_waddr[0]), 12);
        tick(); idle(); tick();

        // syscall beats ov; faulting CP0 write suppressed
        mem_valid = 1; mem_flags = 32'h900; mem_cp0_we = 1; mem_cp0_waddr = 5'd14; mem_cp0_wdata = 32'hdead;
        @(negedge clk);
        chk("pri_sys", 0, o_exc[0], 32'h08);
        chk("pri_sys", 1, o_exc[1], 32'h08);
        tick(); idle();
        @(negedge clk);
        chk("sup_we", 0, 32'(o_we[0]), 0);
        chk("sup_we", 1, 32'(o_we[1]), 0);
        tick(); tick(); tick();
        mem_valid = 1; mem_flags = 32'h200; mem_cp0_we = 1; mem_cp0_waddr = 5'd12; mem_cp0_wdata = 32'h1;
        @(negedge clk);
        chk("pri_inv", 0, o_exc[0], 32'h0a);
        tick(); idle();
        @(negedge clk);
        chk("sup_we2", 0, 32'(o_we[0]), 0);
        tick(); tick(); tick();

        // eret takes the forwarded EPC, not the stale CP0 value
        mem_valid = 1; mem_cp0_we = 1; mem_cp0_waddr = 5'd14; mem_cp0_wdata = 32'hBFC0_0100; epc_i = 32'h1234;
        tick();
        mem_cp0_we = 0; mem_flags = 32'h1000;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("eret_exc", d, o_exc[d], 32'h0e);
            chk("eret_npc", d, o_npc[d], 32'hBFC0_0100);
        end
        tick(); idle(); tick(); tick(); tick();

        // 3-cycle flush; second syscall ignored; wb_stall does not keep the write
        mem_valid = 1; mem_cp0_we = 1; mem_cp0_waddr = 5'd9; mem_cp0_wdata = 32'h5;
        tick();
        mem_flags = 32'h100; wb_stall = 1;
        @(negedge clk);
        chk("h_we_pre", 1, 32'(o_we[1]), 1);
        chk("h_flush0", 1, 32'(o_flush[1]), 1);
        tick();
        @(negedge clk);
        chk("h_exc1", 1, o_exc[1], 0);
        chk("h_flush1", 1, 32'(o_flush[1]), 1);
        chk("h_we1", 1, 32'(o_we[1]), 0);
        tick();
        @(negedge clk);
        chk("h_flush2", 1, 32'(o_flush[1]), 1);
        chk("h_npc2", 1, o_npc[1], 32'h20);
        tick(); idle();
        @(negedge clk);
        chk("h_flush3", 1, 32'(o_flush[1]), 0);
        tick();

        // reset in the middle of HOLD
        mem_valid = 1; mem_flags = 32'h100;
        tick(); idle(); rst = 1;
        @(negedge clk);
        chk("r_hold", 1, 32'(o_flush[1]), 1);
        tick(); rst = 0;
        @(negedge clk);
        chk("r_flush", 1, 32'(o_flush[1]), 0);
        chk("r_exc", 1, o_exc[1], 0);
        chk("r_npc", 1, o_npc[1], 0);
        chk("r_we", 1, 32'(o_we[1]), 0);
        tick();

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            rst       = ($urandom_range(99) == 0);
            mem_valid = ($urandom_range(9) != 0);
            r = 32'h0;
            for (int b = 8; b <= 12; b++) if ($urandom_range(7) == 0) r[b] = 1'b1;
            mem_flags = ($urandom() & 32'hFFFF_E0FF) | r;
            mem_addr  = $urandom();
            mem_dslot = 1'($urandom_range(1));
            mem_cp0_we = 1'($urandom_range(1));
            case ($urandom_range(4))
                0: mem_cp0_waddr = 5'd12;
                1: mem_cp0_waddr = 5'd13;
                2: mem_cp0_waddr = 5'd14;
                3: mem_cp0_waddr = 5'd9;
                default: mem_cp0_waddr = 5'($urandom_range(31));
            endcase
            mem_cp0_wdata = $urandom();
            mem_stall = ($urandom_range(4) == 0);
            wb_stall  = ($urandom_range(4) == 0);
            st_i = $urandom() & 32'hFFFF_FFFC;
            st_i[0] = ($urandom_range(3) != 0);
            st_i[1] = ($urandom_range(3) == 0);
            ca_i  = $urandom() & (($urandom_range(1) == 0) ? 32'hFFFF_00FF : 32'hFFFF_FFFF);
            epc_i = $urandom();
            tick();
        end
        idle(); rst = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
